// File: rtl/slice_cfg_pkg.sv
// Shared types and constants for the slice configuration loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slice_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_PAYLOAD,
    ST_CHK,
    ST_COMMIT
  } cfg_state_t;

  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         BYTES_PER_SLICE = 2;
  localparam int         LUT_INIT_W      = 8;

endpackage

// File: rtl/cfg_checksum.sv
// Running 8-bit XOR over accepted payload bytes, registered output.
// Latency: sum reflects a byte one edge after en is sampled high.
// Backpressure: none; the caller qualifies en with its own handshake.
//
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   clear       zero the accumulator (wins over en)
//   en          fold in_data into the accumulator
//   in_data     byte to fold
//   sum         current running XOR
module cfg_checksum (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] in_data,
  output logic [7:0] sum
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = 8'h00;
    end else if (en) begin
      sum_d = sum_q ^ in_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/slice_cfg_loader.sv
// Byte-serial framed config loader; commits all LUT init words at once.
// Latency: cfg_out/done update one cycle after the last frame byte is accepted.
// Backpressure: in_ready low only during the single COMMIT cycle.
//
// Optional feature: SLICE_CFG_CHECKSUM_EN adds the trailing XOR check byte.
// Without it the frame ends after the payload and only a bad COUNT errors.
//
// Ports:
//   CLK, RST_N                     clock, asynchronous active-low reset
//   in_data/in_valid/in_ready      byte stream, transfers on valid && ready
//   cfg_out                        committed config, 16 bits per slice
//                                  (LUT A in low byte, LUT B in high byte)
//   cfg_valid                      some frame has committed since reset
//   busy                           FSM not idle
//   done / err                     one-cycle commit / rejection pulses
module slice_cfg_loader
  import slice_cfg_pkg::*;
#(
  parameter int NUM_SLICES = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_SLICES*16-1:0] cfg_out,
  output logic                     cfg_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int         CFG_W = NUM_SLICES * BYTES_PER_SLICE * LUT_INIT_W;
  localparam int         IDX_W = $clog2(BYTES_PER_SLICE * NUM_SLICES);
  localparam logic [7:0] MAX_N = 8'(NUM_SLICES);

  cfg_state_t         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   cfg_q, cfg_d;
  logic               cfg_valid_q, cfg_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               acc;
  logic [9:0]         last_idx;
  logic               last_byte;

  assign acc       = in_valid && in_ready;
  // Index of the final payload byte, 2*N-1; 10 bits covers N up to 255.
  assign last_idx  = {1'b0, cnt_q, 1'b0} - 10'd1;
  assign last_byte = (10'(idx_q) == last_idx);

`ifdef SLICE_CFG_CHECKSUM_EN
  logic       xor_clr;
  logic       xor_en;
  logic [7:0] xor_sum;

  cfg_checksum u_checksum (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .clear   (xor_clr),
    .en      (xor_en),
    .in_data (in_data),
    .sum     (xor_sum)
  );
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    cfg_d       = cfg_q;
    cfg_valid_d = cfg_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef SLICE_CFG_CHECKSUM_EN
    xor_clr     = 1'b0;
    xor_en      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // Non-SYNC bytes are dropped without complaint to allow resync.
        if (acc && in_data == SYNC_BYTE) begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (acc) begin
          if (in_data == 8'd0 || in_data > MAX_N) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d    = in_data;
            // Seeding from the live config keeps slices >= N unchanged.
            shadow_d = cfg_q;
            idx_d    = '0;
`ifdef SLICE_CFG_CHECKSUM_EN
            xor_clr  = 1'b1;
`endif
            state_d  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (acc) begin
          shadow_d[{idx_q, 3'b000} +: 8] = in_data;
`ifdef SLICE_CFG_CHECKSUM_EN
          xor_en = 1'b1;
`endif
          if (last_byte) begin
`ifdef SLICE_CFG_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_COMMIT;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SLICE_CFG_CHECKSUM_EN
      ST_CHK: begin
        if (acc) begin
          if (in_data == xor_sum) begin
            state_d = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_COMMIT: begin
        cfg_d       = shadow_q;
        cfg_valid_d = 1'b1;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      idx_q       <= '0;
      shadow_q    <= '0;
      cfg_q       <= '0;
      cfg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      cfg_q       <= cfg_d;
      cfg_valid_q <= cfg_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q != ST_COMMIT);
  assign busy      = (state_q != ST_IDLE);
  assign cfg_out   = cfg_q;
  assign cfg_valid = cfg_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_slice_cfg_loader.sv
// Scoreboard bench for slice_cfg_loader with NUM_SLICES = 4.
module tb_slice_cfg_loader;

  localparam int NS = 4;
`ifdef SLICE_CFG_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   cfg_out;
  logic          cfg_valid;
  logic          busy;
  logic          done;
  logic          err;

  always #5 CLK = ~CLK;

  slice_cfg_loader #(.NUM_SLICES(NS)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_err;
    logic [63:0] cfg;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] model = '0;
  logic [63:0] prev_cfg = '0;
  logic [7:0]  pay [8];
  bit          rand_gaps = 1'b0;
  int          done_cnt = 0;
  int          rdy_low_cnt = 0;

  // Output monitor: every done/err pulse must match the next expectation.
  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_cfg = '0;
    end else begin
      if (!in_ready) rdy_low_cnt++;
      if (done || err) begin
        check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check_eq("event_is_err", 64'(err), 64'(mon_e.is_err));
          check_eq("cfg_out", cfg_out, mon_e.cfg);
          if (done) begin
            done_cnt++;
            check_eq("cfg_valid", 64'(cfg_valid), 64'd1);
          end
        end
      end else if (cfg_out !== prev_cfg) begin
        check_eq("cfg_stable", cfg_out, prev_cfg);
      end
      prev_cfg = cfg_out;
    end
  end

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int guard;
    if (rand_gaps) begin
      int g = $urandom_range(0, 3);
      repeat (g) begin
        @(posedge CLK);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    rdy      = 1'b0;
    guard    = 0;
    while (!rdy && guard < 200) begin
      @(negedge CLK);
      rdy = in_ready;
      @(posedge CLK);
      guard++;
    end
    #1;
    in_valid = 1'b0;
    if (!rdy) check_eq("in_ready_timeout", 64'(rdy), 64'd1);
  endtask

  task automatic send_frame(input logic [7:0] n, input bit bad_chk);
    logic [7:0] x;
    exp_t       e;
    x = 8'h00;
    if (n == 8'd0 || n > 8'(NS)) begin
      e.is_err = 1'b1;
      e.cfg    = model;
      sb.push_back(e);
      send_byte(8'hA5);
      send_byte(n);
    end else begin
      for (int i = 0; i < 2 * int'(n); i++) x ^= pay[i];
      if (CK && bad_chk) begin
        e.is_err = 1'b1;
      end else begin
        e.is_err = 1'b0;
        for (int i = 0; i < 2 * int'(n); i++) model[i*8 +: 8] = pay[i];
      end
      e.cfg = model;
      sb.push_back(e);
      send_byte(8'hA5);
      send_byte(n);
      for (int i = 0; i < 2 * int'(n); i++) send_byte(pay[i]);
      if (CK) send_byte(bad_chk ? (x ^ 8'h11) : x);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() > 0 && g < 50) begin
      @(posedge CLK);
      #1;
      g++;
    end
    @(posedge CLK);
    #1;
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cfg_out"},   cfg_out,          64'd0);
    check_eq({tag, "_cfg_valid"}, 64'(cfg_valid),   64'd0);
    check_eq({tag, "_busy"},      64'(busy),        64'd0);
    check_eq({tag, "_in_ready"},  64'(in_ready),    64'd1);
    check_eq({tag, "_done_err"},  64'({done, err}), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // Two slices loaded, upper slices stay zero.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_frame(8'd2, 1'b0);
    wait_drain();
    check_eq("frame1_cfg", cfg_out, 64'h0000_0000_4433_2211);

    // One slice reloaded, slice 1 untouched.
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_frame(8'd1, 1'b0);
    wait_drain();
    check_eq("frame2_cfg", cfg_out, 64'h0000_0000_4433_BBAA);

    // Bad checksum, then a SYNC driven straight into the err cycle.
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_frame(8'd1, 1'b1);
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_frame(8'd1, 1'b0);
    wait_drain();
    check_eq("b2b_cfg", cfg_out, model);

    // Illegal counts back to back, then idle garbage.
    send_frame(8'd0, 1'b0);
    send_frame(8'd5, 1'b0);
    send_byte(8'h00);
    send_byte(8'hFF);
    check_eq("garbage_busy", 64'(busy), 64'd0);
    wait_drain();

    // Random gaps on in_valid across full and partial frames.
    rand_gaps = 1'b1;
    for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
    send_frame(8'd4, 1'b0);
    for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
    send_frame(8'd3, 1'b0);
    rand_gaps = 1'b0;
    wait_drain();
    check_eq("rand_cfg", cfg_out, model);

    // Reset in the middle of a payload.
    send_byte(8'hA5);
    send_byte(8'd2);
    send_byte(8'h77);
    check_eq("mid_busy", 64'(busy), 64'd1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
    send_frame(8'd2, 1'b0);
    wait_drain();
    check_eq("post_rst_cfg", cfg_out, 64'h0000_0000_0403_0201);

    check_eq("rdy_low_vs_commits", 64'(rdy_low_cnt), 64'(done_cnt));
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
